led_pwm_driver: RTL and testbench

- Downstream output stage for the board LEDs.
- Takes the logical LED on/off pattern from the blink/pattern stage and applies a per-channel 8-bit PWM brightness.
- Drives the active-low LED pins.
- Duty values are written through a simple register-write port.
- Duty values are double-buffered and applied only at PWM period boundaries, so brightness changes never glitch.

---
 rtl/led_pwm_driver.sv | 85 ++++++++
 tb/tb_led_pwm_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - per-channel 8-bit PWM stage driving active-low board LEDs
// Optional LED_PWM_FADE_EN: active duty ramps one step per period toward the shadow value.
module led_pwm_driver #(
  parameter int CLOCK_XTAL = 27000000,
  parameter int LED_NUM    = 6,
  parameter int PWM_FREQ   = 1000,
  parameter int PRESCALE   = ((CLOCK_XTAL / (PWM_FREQ * 256)) > 0) ?
                             (CLOCK_XTAL / (PWM_FREQ * 256)) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LED_NUM-1:0] led_mask,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [7:0]         wr_data,
  output logic               period_start,
  output logic [LED_NUM-1:0] leds
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]    presc_q, presc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               tick, boundary;
  logic               period_start_q;
  logic [LED_NUM-1:0] leds_q, leds_d;
  logic [7:0]         shadow_q [LED_NUM];
  logic [7:0]         shadow_d [LED_NUM];
  logic [7:0]         active_q [LED_NUM];
  logic [7:0]         active_d [LED_NUM];

  assign tick     = (presc_q == PS_LAST);
  assign boundary = tick && (cnt_q == 8'hFF);
  assign presc_d  = tick ? '0 : presc_q + PS_W'(1);
  assign cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;

  // Active duty only moves on the boundary and reads the pre-edge shadow,
  // so a write landing on the boundary cycle waits one more period.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    leds_d   = '1;
    for (int i = 0; i < LED_NUM; i++) begin
      if (wr_en && (wr_addr == 3'(i))) begin
        shadow_d[i] = wr_data;
      end
      if (boundary) begin
`ifdef LED_PWM_FADE_EN
        if (active_q[i] < shadow_q[i]) begin
          active_d[i] = active_q[i] + 8'd1;
        end else if (active_q[i] > shadow_q[i]) begin
          active_d[i] = active_q[i] - 8'd1;
        end
`else
        active_d[i] = shadow_q[i];
`endif
      end
      leds_d[i] = ~(led_mask[i] & ((active_q[i] == 8'hFF) | (cnt_q < active_q[i])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      leds_q         <= '1;
      for (int i = 0; i < LED_NUM; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= boundary;
      leds_q         <= leds_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
    end
  end

  assign period_start = period_start_q;
  assign leds         = leds_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - directed scoreboard bench for led_pwm_driver (256-clock period)
module tb_led_pwm_driver;

`ifdef LED_PWM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] led_mask;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       period_start;
  logic [5:0] leds;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0][8:0] lows;
    logic [5:0][1:0] chg;
  } exp_t;

  exp_t sb_q[$];
  logic [5:0][7:0] duty;

  led_pwm_driver #(
    .CLOCK_XTAL(256000),
    .LED_NUM   (6),
    .PWM_FREQ  (1000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .led_mask    (led_mask),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .period_start(period_start),
    .leds        (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Low time per channel is the duty itself, except 255 which is DC on.
  function automatic exp_t mk(input logic [5:0][7:0] d);
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      e.lows[c] = (d[c] == 8'hFF) ? 9'd256 : {1'b0, d[c]};
      e.chg[c]  = (d[c] != 8'h00 && d[c] != 8'hFF) ? 2'd1 : 2'd0;
    end
    return e;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_ps(input string tag, output int n, output int bad);
    n   = 0;
    bad = 0;
    while (period_start !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
      if (leds !== 6'h3F) bad++;
    end
    chk(tag, period_start, 1);
  endtask

  // Called on the negedge where period_start is high; samples one full period.
  task automatic measure(input string tag, input int wr_idx, input logic [2:0] wa,
                         input logic [7:0] wd);
    exp_t            e;
    logic [5:0][8:0] lows;
    logic [5:0][1:0] chg;
    logic [5:0]      prev;
    int              psn;
    lows = '0;
    chg  = '0;
    psn  = 0;
    prev = leds;
    for (int s = 0; s < 256; s++) begin
      if (s == wr_idx) begin
        wr_addr = wa;
        wr_data = wd;
        wr_en   = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
      if (period_start === 1'b1) psn++;
      for (int c = 0; c < 6; c++) begin
        if (leds[c] === 1'b0) lows[c] = lows[c] + 9'd1;
        if (s > 0 && leds[c] !== prev[c] && chg[c] != 2'd3) chg[c] = chg[c] + 2'd1;
      end
      prev = leds;
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_lows"}, lows, e.lows);
      chk({tag, "_edges"}, chg, e.chg);
    end
    chk({tag, "_ps_count"}, psn, 1);
    chk({tag, "_ps_end"}, period_start, 1);
  endtask

  initial begin
    int n;
    int bad;
    int exp5 [7];
    rst_n    = 1'b0;
    led_mask = 6'h00;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 8'd0;
    duty     = '0;
    if (FADE) exp5 = '{1, 2, 3, 4, 4, 3, 2};
    else      exp5 = '{4, 4, 4, 4, 4, 2, 2};

    repeat (3) @(negedge clk);
    chk("reset_leds", leds, 6'h3F);
    chk("reset_ps", period_start, 0);

    rst_n    = 1'b1;
    led_mask = 6'h3F;
    wr(3'd2, 8'hFF);
    wait_ps("first_ps_seen", n, bad);
    chk("first_ps_latency", n + 1, 256);

    repeat (44) @(negedge clk);
    chk("pre_reset_leds", leds, FADE ? 6'h3F : 6'b111011);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_leds", leds, 6'h3F);
    chk("async_reset_ps", period_start, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ps("rel_ps_seen", n, bad);
    chk("rel_ps_latency", n, 256);
    chk("reset_clears_duty", bad, 0);

`ifndef LED_PWM_FADE_EN
    repeat (100) @(negedge clk);
    wr(3'd0, 8'd64);
    wr(3'd1, 8'd0);
    wr(3'd2, 8'hFF);
    wr(3'd4, 8'hFF);
    wait_ps("duty_ps_seen", n, bad);
    chk("no_apply_before_boundary", bad, 0);

    duty[0] = 8'd64;
    duty[2] = 8'hFF;
    duty[4] = 8'hFF;
    sb_q.push_back(mk(duty));
    sb_q.push_back(mk(duty));
    sb_q.push_back(mk(duty));
    sb_q.push_back(mk(duty));
    duty[3] = 8'd128;
    sb_q.push_back(mk(duty));
    measure("p1", -1, 3'd0, 8'd0);
    measure("p2", -1, 3'd0, 8'd0);
    measure("p3_bwrite", 255, 3'd3, 8'd128);
    measure("p4_ch3_old", -1, 3'd0, 8'd0);
    measure("p5_ch3_new", -1, 3'd0, 8'd0);

    repeat (10) @(negedge clk);
    chk("mask_before", leds, 6'b100010);
    led_mask[4] = 1'b0;
    #1;
    chk("mask_same_cycle", leds, 6'b100010);
    @(negedge clk);
    chk("mask_one_clk", leds, 6'b110010);
    led_mask = 6'h3F;

    wr(3'd6, 8'hAA);
    wr(3'd7, 8'hAA);
    wait_ps("oor_ps_seen", n, bad);
    sb_q.push_back(mk(duty));
    measure("oor", -1, 3'd0, 8'd0);
`endif

    repeat (50) @(negedge clk);
    wr(3'd5, 8'd4);
    wait_ps("ch5_ps_seen", n, bad);
    for (int k = 0; k < 7; k++) begin
      duty[5] = 8'(exp5[k]);
      sb_q.push_back(mk(duty));
    end
    for (int k = 0; k < 7; k++) begin
      if (k == 4) measure($sformatf("ch5_w%0d", k), 0, 3'd5, 8'd2);
      else        measure($sformatf("ch5_w%0d", k), -1, 3'd0, 8'd0);
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
